// File: rtl/cs_sched_pkg.sv
// Shared types and constants for the partition transfer scheduler.
package cs_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } sched_state_t;

  localparam logic XFER_PUT = 1'b0;
  localparam logic XFER_GET = 1'b1;

endpackage

// File: rtl/cs_rr_arb.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module cs_rr_arb #(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned SW      = $clog2(N_SLOTS)
) (
  input  logic [N_SLOTS-1:0] req_i,
  input  logic [SW-1:0]      ptr_i,
  output logic [N_SLOTS-1:0] gnt_o,
  output logic [SW-1:0]      idx_o,
  output logic               any_o
);

  logic          found;
  logic [SW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < N_SLOTS; i++) begin
      cand = SW'((32'(ptr_i) + i) % N_SLOTS);
      if (!found && req_i[cand]) begin
        found        = 1'b1;
        gnt_o[cand]  = 1'b1;
        idx_o        = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/part_xfer_sched.sv
// Schedules per-slot put/get transfers onto one transport channel, holding the
// slot's mission clock frozen while a get is outstanding.
module part_xfer_sched
  import cs_sched_pkg::*;
#(
  parameter int unsigned N_SLOTS  = 4,
  parameter int unsigned WD_LIMIT = 100,
  parameter int unsigned SW       = $clog2(N_SLOTS),
  parameter int unsigned WW       = $clog2(WD_LIMIT + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_SLOTS-1:0] slot_req_i,
  input  logic [N_SLOTS-1:0] slot_get_i,
  output logic [N_SLOTS-1:0] freeze_clk_o,
  output logic [N_SLOTS-1:0] slot_done_o,
  output logic [N_SLOTS-1:0] slot_err_o,
  output logic               ovf_o,
  output logic               xfer_valid_o,
  input  logic               xfer_ready_i,
  output logic [SW-1:0]      xfer_slot_o,
  output logic               xfer_get_o,
  input  logic               rsp_valid_i,
  input  logic               rsp_hit_i,
  output logic               busy_o
);

  sched_state_t state_q, state_d;

  logic [N_SLOTS-1:0] pend_q, pend_d;
  logic [N_SLOTS-1:0] dir_q, dir_d;
  logic [N_SLOTS-1:0] freeze_q, freeze_d;
  logic               ovf_q, ovf_d;
  logic [SW-1:0]      cur_q, cur_d;
  logic [SW-1:0]      ptr_q, ptr_d;
  logic [WW-1:0]      wd_q, wd_d;

  logic               xfer_valid_q, xfer_valid_d;
  logic               xfer_get_q, xfer_get_d;
  logic [N_SLOTS-1:0] done_q, done_d;
  logic [N_SLOTS-1:0] err_q, err_d;
  logic               busy_q, busy_d;

  logic [N_SLOTS-1:0] arb_gnt;
  logic [SW-1:0]      arb_idx;
  logic               arb_any;

  logic               fin_done;
  logic               fin_err;
  logic [N_SLOTS-1:0] fin_vec;
  logic [N_SLOTS-1:0] accept;

  cs_rr_arb #(
    .N_SLOTS (N_SLOTS),
    .SW      (SW)
  ) u_arb (
    .req_i (pend_q),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      dir_q        <= '0;
      freeze_q     <= '0;
      ovf_q        <= 1'b0;
      cur_q        <= '0;
      ptr_q        <= '0;
      wd_q         <= '0;
      xfer_valid_q <= 1'b0;
      xfer_get_q   <= 1'b0;
      done_q       <= '0;
      err_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      dir_q        <= dir_d;
      freeze_q     <= freeze_d;
      ovf_q        <= ovf_d;
      cur_q        <= cur_d;
      ptr_q        <= ptr_d;
      wd_q         <= wd_d;
      xfer_valid_q <= xfer_valid_d;
      xfer_get_q   <= xfer_get_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    wd_d     = wd_q;
    ptr_d    = ptr_q;
    fin_done = 1'b0;
    fin_err  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = ISSUE;
          cur_d   = arb_idx;
          wd_d    = '0;
        end
      end
      ISSUE: begin
        if (xfer_valid_q && xfer_ready_i) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid_i) begin
          if (dir_q[cur_q] == XFER_PUT || rsp_hit_i) begin
            fin_done = 1'b1;
            state_d  = IDLE;
          end else if (wd_q == WW'(WD_LIMIT)) begin
            fin_err = 1'b1;
            state_d = IDLE;
          end else begin
            wd_d    = wd_q + WW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fin_done || fin_err) begin
      ptr_d = (cur_q == SW'(N_SLOTS - 1)) ? '0 : cur_q + SW'(1);
    end

    // A request landing on the slot that finishes this cycle is a fresh transfer.
    fin_vec  = N_SLOTS'(fin_done || fin_err) << cur_q;
    accept   = slot_req_i & (~pend_q | fin_vec);
    pend_d   = (pend_q & ~fin_vec) | accept;
    dir_d    = (dir_q & ~accept) | (slot_get_i & accept);
    freeze_d = (freeze_q & ~fin_vec) | (accept & slot_get_i);
    ovf_d    = ovf_q | (|(slot_req_i & pend_q & ~fin_vec));
  end

  // Registered-output next values
  always_comb begin
    xfer_valid_d = (state_d == ISSUE);
    xfer_get_d   = (state_q == IDLE) ? |(arb_gnt & dir_q) : dir_q[cur_q];
    done_d       = fin_done ? fin_vec : '0;
    err_d        = fin_err  ? fin_vec : '0;
    busy_d       = (state_d != IDLE);
  end

  assign freeze_clk_o = freeze_q;
  assign slot_done_o  = done_q;
  assign slot_err_o   = err_q;
  assign ovf_o        = ovf_q;
  assign xfer_valid_o = xfer_valid_q;
  assign xfer_slot_o  = cur_q;
  assign xfer_get_o   = xfer_get_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_part_xfer_sched.sv
// Scoreboard bench: issued requests push expected commands/completions, a monitor pops and compares.
module tb_part_xfer_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned WD = 100;
  localparam int unsigned SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  slot_req, slot_get, freeze, done, err;
  logic          ovf, xv, xr, xg, rv, rh, busy;
  logic [SW-1:0] xs;

  always #5 clk = ~clk;

  part_xfer_sched #(
    .N_SLOTS  (N),
    .WD_LIMIT (WD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slot_req_i   (slot_req),
    .slot_get_i   (slot_get),
    .freeze_clk_o (freeze),
    .slot_done_o  (done),
    .slot_err_o   (err),
    .ovf_o        (ovf),
    .xfer_valid_o (xv),
    .xfer_ready_i (xr),
    .xfer_slot_o  (xs),
    .xfer_get_o   (xg),
    .rsp_valid_i  (rv),
    .rsp_hit_i    (rh),
    .busy_o       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cmd_q[$];   // slot*2 + get, one entry per command issued
  int cpl_q[$];   // slot*4 + (2 = done, 1 = err)
  int miss_left[N];
  logic [N-1:0] exp_freeze = '0;
  int mptr = 0;   // reference round-robin pointer
  bit sim_arm = 1'b0;
  bit sim_fire = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (xv && xr) begin
          if (cmd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_cmd: got slot %0d get %0d required none", xs, xg);
          end else begin
            e = cmd_q.pop_front();
            check("cmd", 32'({xs, xg}), 32'(e));
          end
        end
        for (int k = 0; k < N; k++) begin
          if (done[k] || err[k]) begin
            exp_freeze[k] = 1'b0;
            if (cpl_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_cpl: got slot %0d done %0d err %0d required none",
                       k, done[k], err[k]);
            end else begin
              e = cpl_q.pop_front();
              check("cpl", 32'(k * 4 + 2 * int'(done[k]) + int'(err[k])), 32'(e));
            end
          end
        end
        check("freeze", 32'(freeze), 32'(exp_freeze));
      end
    end
  end

  // Transport responder
  initial begin
    bit hs, inflight, r_get, hs_get;
    int dly, r_slot, hs_slot;
    xr = 1'b0; rv = 1'b0; rh = 1'b0;
    inflight = 1'b0; dly = 0; r_slot = 0; r_get = 1'b0;
    forever begin
      @(negedge clk);
      hs      = xv && xr && !rst;
      hs_slot = int'(xs);
      hs_get  = xg;
      @(posedge clk);
      #1;
      rv = 1'b0;
      rh = 1'b0;
      if (sim_fire) begin
        slot_req = '0;
        sim_fire = 1'b0;
      end
      if (rst) begin
        inflight = 1'b0;
      end else begin
        if (inflight && dly > 0) dly--;
        if (hs) begin
          inflight = 1'b1;
          dly      = $urandom_range(0, 2);
          r_slot   = hs_slot;
          r_get    = hs_get;
        end
        if (inflight && dly == 0) begin
          rv       = 1'b1;
          inflight = 1'b0;
          if (r_get) begin
            if (miss_left[r_slot] > 0) begin
              rh = 1'b0;
              miss_left[r_slot]--;
            end else begin
              rh = 1'b1;
            end
          end else begin
            rh = 1'($urandom % 2);
          end
          if (sim_arm && r_slot == 1 && !r_get) begin
            slot_req = 4'b0010;
            slot_get = '0;
            sim_arm  = 1'b0;
            sim_fire = 1'b1;
          end
        end
      end
      xr = ($urandom % 4) != 0;
    end
  end

  // Raise requests in one cycle and push what the spec says must follow.
  task automatic issue(input logic [N-1:0] mask, input logic [N-1:0] gets);
    int last;
    last = mptr;
    @(posedge clk);
    #1;
    slot_req = mask;
    slot_get = gets;
    for (int i = 0; i < N; i++) begin
      int k, polls;
      bit e;
      k = (mptr + i) % N;
      if (mask[k]) begin
        if (gets[k]) begin
          e     = miss_left[k] > WD;
          polls = e ? WD + 1 : miss_left[k] + 1;
        end else begin
          e     = 1'b0;
          polls = 1;
        end
        repeat (polls) cmd_q.push_back(k * 2 + int'(gets[k]));
        cpl_q.push_back(k * 4 + (e ? 1 : 2));
        last = k;
      end
    end
    mptr = (last + 1) % N;
    @(posedge clk);
    exp_freeze = exp_freeze | (mask & gets);
    #1;
    slot_req = '0;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((cmd_q.size() != 0 || cpl_q.size() != 0 || busy) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check({tag, "_drain"}, 32'(t < 3000), 32'd1);
    if (t >= 3000) begin
      cmd_q.delete();
      cpl_q.delete();
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    slot_req = '0;
    slot_get = '0;
    for (int k = 0; k < N; k++) miss_left[k] = 0;
    repeat (3) @(negedge clk);
    check("rst_freeze", 32'(freeze), 32'd0);
    check("rst_done", 32'({done, err}), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_valid", 32'(xv), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd", 32'({xs, xg}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fairness, two rounds from ptr=0
    issue(4'b1011, 4'b0000);
    drain("fair1");
    issue(4'b1011, 4'b0000);
    drain("fair2");

    issue(4'b0001, 4'b0000);
    drain("put0");

    miss_left[3] = 5;
    issue(4'b1000, 4'b1000);
    drain("get_miss");

    miss_left[2] = 1000;
    issue(4'b0100, 4'b0100);
    drain("watchdog");

    // Request lands on slot 1 in its completion cycle
    sim_arm = 1'b1;
    issue(4'b0010, 4'b0000);
    cmd_q.push_back(1 * 2);
    cpl_q.push_back(1 * 4 + 2);
    drain("simul");
    check("simul_ovf", 32'(ovf), 32'd0);

    // Second request on a still-pending slot
    issue(4'b0010, 4'b0000);
    slot_req = 4'b0010;
    @(posedge clk);
    #1;
    slot_req = '0;
    drain("ovf");
    check("ovf_set", 32'(ovf), 32'd1);

    for (int b = 0; b < 40; b++) begin
      logic [N-1:0] m, g;
      m = N'($urandom_range(1, (1 << N) - 1));
      g = N'($urandom);
      for (int k = 0; k < N; k++)
        miss_left[k] = ($urandom % 20 == 0) ? 150 : $urandom_range(0, 4);
      issue(m, g);
      drain("rand");
    end

    // Reset while waiting on a get response
    miss_left[2] = 1000;
    issue(4'b0100, 4'b0100);
    t = 0;
    while (!(busy && !xv) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("wait_rsp_reached", 32'(t < 50), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_freeze", 32'(freeze), 32'd0);
    check("arst_valid", 32'(xv), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    cmd_q.delete();
    cpl_q.delete();
    exp_freeze = '0;
    mptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    issue(4'b0001, 4'b0000);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
